// File: rtl/hbmc_pkg.sv
`timescale 1ns/1ps
// hbmc_pkg
//   Shared definitions for the HyperBus controller clock-domain-crossing blocks.
//   Holds the 2-bit state encoding of the handshake receiver FSM.
package hbmc_pkg;

  // Code 2'd3 is unused; the receiver treats it as WARMUP.
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_VALID  = 2'd2
  } hs_state_t;

endpackage

// File: rtl/hbmc_bit_sync.sv
`timescale 1ns/1ps
// hbmc_bit_sync
//   Multi-flop single-bit synchronizer for a level/toggle signal that is
//   asynchronous to clk. C_SYNC_STAGES must be >= 2.
// Ports
//   clk    in  destination clock
//   arstn  in  asynchronous active-low reset, chain loads C_RESET_STATE
//   d      in  asynchronous input bit
//   q      out synchronized bit (last flop of the chain)
module hbmc_bit_sync #(
  parameter int   C_SYNC_STAGES = 3,
  parameter logic C_RESET_STATE = 1'b0
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [C_SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      chain <= {C_SYNC_STAGES{C_RESET_STATE}};
    end else begin
      chain <= {chain[C_SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[C_SYNC_STAGES-1];

endmodule

// File: rtl/hbmc_cdc_hs_rx.sv
`timescale 1ns/1ps
// hbmc_cdc_hs_rx
//   Destination side of a toggle req/ack CDC handshake. A req toggle from the
//   source domain is synchronized, the quasi-static source word is captured and
//   offered as a valid/ready stream, and acceptance returns an ack toggle.
// Ports
//   clk           in   destination clock (rising edge)
//   rst           in   synchronous active-high reset
//   s_req_toggle  in   source req toggle, asynchronous
//   s_data        in   source word, stable while a transfer is in flight
//   s_ack_toggle  out  registered ack toggle back to the source
//   m_data        out  captured word, stable while m_valid
//   m_valid       out  word available
//   m_ready       in   consumer accept
//   overrun       out  sticky: req event arrived while a word was pending
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_WARMUP | after reset; let the synchronizer settle, ignore req events
// ST_IDLE   | waiting for a req event
// ST_VALID  | word presented, waiting for m_ready
module hbmc_cdc_hs_rx
  import hbmc_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_SYNC_STAGES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_req_toggle,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  output logic                    s_ack_toggle,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overrun
);

  localparam int                CNT_W    = $clog2(C_SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(C_SYNC_STAGES + 1);

  hs_state_t               state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    ack_nxt, valid_nxt, ovr_nxt;
  logic [C_DATA_WIDTH-1:0] data_nxt;
  logic                    rst_n_q;
  logic                    req_sync, req_sync_d;
  logic                    evt, evt_q;

  // Registered release keeps the synchronizer's async reset glitch-free.
  always_ff @(posedge clk) begin
    rst_n_q <= ~rst;
  end

  hbmc_bit_sync #(
    .C_SYNC_STAGES (C_SYNC_STAGES),
    .C_RESET_STATE (1'b0)
  ) u_req_sync (
    .clk   (clk),
    .arstn (rst_n_q),
    .d     (s_req_toggle),
    .q     (req_sync)
  );

  assign evt = req_sync ^ req_sync_d;

  // evt is registered before the FSM uses it. Events during warmup are masked
  // so that a req level left high by an unreset source settles silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_d <= 1'b0;
      evt_q      <= 1'b0;
    end else begin
      req_sync_d <= req_sync;
      evt_q      <= evt & (state != ST_WARMUP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_WARMUP;
      cnt          <= '0;
      s_ack_toggle <= 1'b0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      s_ack_toggle <= ack_nxt;
      m_data       <= data_nxt;
      m_valid      <= valid_nxt;
      overrun      <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = s_ack_toggle;
    data_nxt  = m_data;
    valid_nxt = m_valid;
    ovr_nxt   = overrun;
    case (state)
      ST_WARMUP: begin
        valid_nxt = 1'b0;
        if (cnt == CNT_DONE) begin
          // Adopt the current req level as "already acknowledged".
          ack_nxt   = req_sync;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (evt_q) begin
          data_nxt  = s_data;
          valid_nxt = 1'b1;
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        // An event here, even in the accept cycle, is dropped as an overrun.
        if (evt_q) begin
          ovr_nxt = 1'b1;
        end
        if (m_ready) begin
          valid_nxt = 1'b0;
          ack_nxt   = ~s_ack_toggle;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        cnt_nxt   = '0;
        state_nxt = ST_WARMUP;
      end
    endcase
  end

endmodule
